// File: rtl/hann_window_reader_if.sv
`default_nettype none
// ==========================================================================
// hann_window_reader_if : sample-in / coefficient-store / windowed-out bundle
// Revision 1.0
// ==========================================================================
interface hann_window_reader_if #(
   parameter int DATA_W = 16
);
   logic                     in_valid;
   logic signed [DATA_W-1:0] in_data;
   logic                     in_ready;
   logic                     coef_rd_en;
   logic [15:0]              coef_data;
   logic                     out_valid;
   logic signed [DATA_W-1:0] out_data;
   logic                     out_last;

   modport slave (
      input  in_valid, in_data, coef_data,
      output in_ready, coef_rd_en, out_valid, out_data, out_last
   );

   modport master (
      output in_valid, in_data, coef_data,
      input  in_ready, coef_rd_en, out_valid, out_data, out_last
   );
endinterface
`default_nettype wire

// File: rtl/hann_window_reader.sv
`default_nettype none
// ==========================================================================
// hann_window_reader : windows a sample stream with Hann coefficients read
//                      from an auto-incrementing store, replaying after stalls
// Revision 1.0
// ==========================================================================
module hann_window_reader #(
   parameter int FRAME_LEN = 512,
   parameter int ADDR_W    = 9,
   parameter int DATA_W    = 16
) (
   input  wire logic           clk,
   input  wire logic           rst_n,
   input  wire logic           en,
   output logic                busy,
   hann_window_reader_if.slave bus
);
   localparam int                 PROD_W    = DATA_W + 17;
   localparam logic [ADDR_W-1:0]  LAST_IDX  = ADDR_W'(FRAME_LEN - 1);
   localparam bit                 FULL_WRAP = (FRAME_LEN == (1 << ADDR_W));
   localparam logic signed [PROD_W-1:0] SAT_MAX =
      {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [PROD_W-1:0] SAT_MIN =
      {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_RESYNC = 2'd2,
      ST_GAP    = 2'd3
   } state_t;

   state_t                   state_q, state_d;
   logic [ADDR_W-1:0]        idx_q, idx_d;
   logic [ADDR_W-1:0]        rcnt_q, rcnt_d;
   logic                     s1_valid_q, s1_valid_d;
   logic signed [DATA_W-1:0] s1_data_q, s1_data_d;
   logic                     s1_last_q, s1_last_d;
   logic                     out_valid_q, out_valid_d;
   logic signed [DATA_W-1:0] out_data_q, out_data_d;
   logic                     out_last_q, out_last_d;

   logic                     accept;
   logic signed [PROD_W-1:0] prod;
   logic signed [PROD_W-1:0] res;
   logic signed [DATA_W-1:0] sat;

   assign accept = (state_q == ST_RUN) && bus.in_valid;

   // The store address tracks idx only while reads are continuous; any
   // non-reading cycle mid-frame sends us to replay idx reads from address 0.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rcnt_d  = rcnt_q;
      case (state_q)
         ST_IDLE: begin
            if (en) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (accept) begin
               if (idx_q == LAST_IDX) begin
                  idx_d = '0;
                  if (!FULL_WRAP)  state_d = ST_GAP;
                  else if (!en)    state_d = ST_IDLE;
               end else begin
                  idx_d = idx_q + ADDR_W'(1);
               end
            end else if (idx_q != '0) begin
               state_d = ST_RESYNC;
               rcnt_d  = '0;
            end else if (!en) begin
               state_d = ST_IDLE;
            end
         end
         ST_RESYNC: begin
            rcnt_d = rcnt_q + ADDR_W'(1);
            if (rcnt_q == idx_q - ADDR_W'(1)) state_d = ST_RUN;
         end
         ST_GAP: begin
            state_d = en ? ST_RUN : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Stage 1 holds the accepted sample while its coefficient comes back.
   always_comb begin
      s1_valid_d = accept;
      s1_data_d  = accept ? bus.in_data : s1_data_q;
      s1_last_d  = accept ? (idx_q == LAST_IDX) : s1_last_q;

      prod = PROD_W'(s1_data_q) * PROD_W'($signed({1'b0, bus.coef_data}));
      res  = prod >>> 15;
      if (res > SAT_MAX)      sat = SAT_MAX[DATA_W-1:0];
      else if (res < SAT_MIN) sat = SAT_MIN[DATA_W-1:0];
      else                    sat = res[DATA_W-1:0];

      out_valid_d = s1_valid_q;
      out_last_d  = s1_valid_q & s1_last_q;
      out_data_d  = s1_valid_q ? sat : out_data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         rcnt_q      <= '0;
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_last_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         rcnt_q      <= rcnt_d;
         s1_valid_q  <= s1_valid_d;
         s1_data_q   <= s1_data_d;
         s1_last_q   <= s1_last_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   assign bus.in_ready   = (state_q == ST_RUN);
   assign bus.coef_rd_en = ((state_q == ST_RUN) && bus.in_valid) || (state_q == ST_RESYNC);
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.out_last   = out_last_q;
   assign busy           = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hann_window_reader.sv
`default_nettype none
// ==========================================================================
// tb_hann_window_reader : two instances (gapped and self-wrapping frame
//                         lengths) driven randomly and scoreboarded
// Revision 1.0
// ==========================================================================
module tb_hann_window_reader;
   logic   clk = 1'b0;
   longint cyc = 0;
   int     n_checks = 0;
   int     n_errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      longint data;
      bit     last;
      longint cyc;
   } exp_t;

   function automatic void chk(input int inst, input string name,
                               input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL g%0d %s: got %0d expected %0d (t=%0t)", inst, name, act, exp, $time);
      end
   endfunction

   // Windowed value: floor(sample*coef / 2^15), clamped to 16-bit signed.
   function automatic longint win(input longint s, input longint c);
      longint p, q;
      p = s * c;
      if (p >= 0) q = p / 32768;
      else        q = -((-p + 32767) / 32768);
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
      return q;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int FL   = (g == 0) ? 24 : 32;
      localparam int AW   = 5;
      localparam bit FULL = (FL == (1 << AW));

      logic rst_n, en, busy;
      hann_window_reader_if #(.DATA_W(16)) bus ();

      hann_window_reader #(.FRAME_LEN(FL), .ADDR_W(AW), .DATA_W(16)) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (en),
         .busy  (busy),
         .bus   (bus)
      );

      logic [15:0]   mem [1 << AW];
      logic [AW-1:0] st_addr = '0;
      exp_t          sb[$];
      exp_t          mon_e;
      int            pos = 0;
      int            rs_left = 0;
      bit            rs_end = 0;
      bit            post_last = 0;
      bit            post_exp = 0;
      bit            done = 0;

      // Coefficient store: address auto-increments on read, returns to 0 otherwise.
      always @(posedge clk) begin
         bus.coef_data <= mem[st_addr];
         st_addr       <= bus.coef_rd_en ? st_addr + 1'b1 : '0;
      end

      always @(negedge clk) begin
         if (!rst_n) begin
            sb.delete();
            pos = 0; rs_left = 0; rs_end = 0; post_last = 0;
         end else begin
            if (bus.out_valid) begin
               if (sb.size() == 0) begin
                  chk(g, "unexpected_out_valid", 1, 0);
               end else begin
                  mon_e = sb.pop_front();
                  chk(g, "out_data", longint'(bus.out_data), mon_e.data);
                  chk(g, "out_last", longint'(bus.out_last), longint'(mon_e.last));
                  chk(g, "latency_cycle", cyc, mon_e.cyc);
               end
            end
            if (rs_left > 0) begin
               chk(g, "resync_in_ready", longint'(bus.in_ready), 0);
               chk(g, "resync_rd_en", longint'(bus.coef_rd_en), 1);
               rs_left--;
               if (rs_left == 0) rs_end = 1;
            end else begin
               if (rs_end) begin
                  chk(g, "resync_exit_ready", longint'(bus.in_ready), 1);
                  rs_end = 0;
               end
               if (bus.in_ready) chk(g, "run_rd_en", longint'(bus.coef_rd_en), longint'(bus.in_valid));
               else              chk(g, "stopped_rd_en", longint'(bus.coef_rd_en), 0);
            end
            if (post_last) begin
               chk(g, "frame_boundary_ready", longint'(bus.in_ready), longint'(post_exp));
               post_last = 0;
            end
            if (bus.in_ready && bus.in_valid) begin
               sb.push_back('{win(longint'(bus.in_data), longint'(mem[pos])), pos == FL - 1, cyc + 2});
               if (pos == FL - 1) begin
                  post_last = 1;
                  post_exp  = FULL ? en : 1'b0;
               end
               pos = (pos + 1) % FL;
            end else if (bus.in_ready && pos != 0) begin
               rs_left = pos;
            end
         end
      end

      initial begin
         int stall;
         stall = 0;
         for (int k = 0; k < (1 << AW); k++)
            mem[k] = (k % 4 == 0) ? 16'hFFFF : 16'($urandom);
         rst_n = 1'b0; en = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
         repeat (3) @(posedge clk);
         #1;
         chk(g, "reset_in_ready",  longint'(bus.in_ready), 0);
         chk(g, "reset_rd_en",     longint'(bus.coef_rd_en), 0);
         chk(g, "reset_out_valid", longint'(bus.out_valid), 0);
         chk(g, "reset_out_last",  longint'(bus.out_last), 0);
         chk(g, "reset_out_data",  longint'(bus.out_data), 0);
         chk(g, "reset_busy",      longint'(busy), 0);
         rst_n = 1'b1;
         repeat (2) @(posedge clk);
         #1;
         chk(g, "idle_without_en_busy", longint'(busy), 0);
         en = 1'b1;
         for (int c = 0; c < 2500; c++) begin
            if (c == 1200) begin
               rst_n = 1'b0;
               #1;
               chk(g, "midrun_reset_in_ready",  longint'(bus.in_ready), 0);
               chk(g, "midrun_reset_out_valid", longint'(bus.out_valid), 0);
               chk(g, "midrun_reset_out_data",  longint'(bus.out_data), 0);
               chk(g, "midrun_reset_busy",      longint'(busy), 0);
               @(posedge clk);
               #1 rst_n = 1'b1;
            end
            if (stall > 0) begin
               bus.in_valid = 1'b0;
               stall--;
            end else if ($urandom_range(0, 99) < 8) begin
               bus.in_valid = 1'b0;
               stall = $urandom_range(0, 3);
            end else begin
               bus.in_valid = 1'b1;
            end
            case ($urandom_range(0, 3))
               0:       bus.in_data = 16'sh7FFF;
               1:       bus.in_data = 16'sh8000;
               default: bus.in_data = 16'($urandom);
            endcase
            en = ($urandom_range(0, 99) < 95);
            @(posedge clk);
            #1;
         end
         en = 1'b0;
         bus.in_valid = 1'b1;
         for (int w = 0; w < 4 * FL && busy; w++) begin
            bus.in_data = 16'($urandom);
            @(posedge clk);
            #1;
         end
         chk(g, "drain_busy", longint'(busy), 0);
         bus.in_valid = 1'b0;
         repeat (4) @(posedge clk);
         #1;
         chk(g, "drain_in_ready", longint'(bus.in_ready), 0);
         chk(g, "scoreboard_empty", longint'(sb.size()), 0);
         done = 1;
      end
   end

   initial begin
      for (int t = 0; t < 40000; t++) begin
         if (g_dut[0].done && g_dut[1].done) break;
         @(posedge clk);
      end
      if (!(g_dut[0].done && g_dut[1].done)) begin
         n_checks++;
         n_errors++;
         $display("FAIL timeout: stimulus not complete, got %0d%0d expected 11",
                  g_dut[0].done, g_dut[1].done);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
